// File: rtl/rand_cell_picker.sv
// rand_cell_picker: turns the upstream LFSR word into a random grid cell.
// Values outside [0, ROWS*COLS-1] are rejected and redrawn. After MAX_TRIES
// draws the last value is folded back into range instead. The accepted index
// is split into row/column by repeated subtraction of COLS, and the result is
// presented on a valid/ready handshake.
module rand_cell_picker #(
  parameter int NUM_LEN   = 10,
  parameter int ROWS      = 15,
  parameter int COLS      = 40,
  parameter int MAX_TRIES = 16,
  parameter int RW        = 4,
  parameter int CW        = 6
) (
  input  logic               clk,
  input  logic               rst,        // asynchronous, active low
  input  logic               req,
  input  logic [NUM_LEN-1:0] lfsr_in,
  output logic               lfsr_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RW-1:0]      row,
  output logic [CW-1:0]      col,
  output logic [NUM_LEN-1:0] idx,
  output logic               busy,
  output logic               fallback
);

  localparam int RANGE = ROWS * COLS;
  localparam int TW    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  localparam logic [NUM_LEN-1:0] RANGE_N  = RANGE[NUM_LEN-1:0];
  localparam logic [NUM_LEN-1:0] COLS_N   = COLS[NUM_LEN-1:0];
  localparam logic [TW-1:0]      LAST_TRY = TW'(MAX_TRIES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      tries_q, tries_d;
  logic [NUM_LEN-1:0] rem_q,   rem_d;
  logic [NUM_LEN-1:0] idx_q,   idx_d;
  logic [RW-1:0]      row_q,   row_d;
  logic [CW-1:0]      col_q,   col_d;
  logic               fb_q,    fb_d;

  // State and datapath registers; reset clears everything so no stale
  // or partial result survives a mid-operation reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tries_q <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      fb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      fb_q    <= fb_d;
    end
  end

  // Next-state, datapath updates and the state-decoded strobes.
  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    row_d     = row_q;
    col_d     = col_q;
    fb_d      = fb_q;
    lfsr_en   = 1'b0;
    out_valid = 1'b0;
    busy      = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (req) begin
          tries_d = '0;
          fb_d    = 1'b0;
          state_d = S_DRAW;
        end
      end

      S_DRAW: begin
        // The value is consumed this cycle; the LFSR steps on the same edge.
        lfsr_en = 1'b1;
        if (lfsr_in < RANGE_N) begin
          idx_d   = lfsr_in;
          rem_d   = lfsr_in;
          row_d   = '0;
          state_d = S_DIV;
        end else if (tries_q == LAST_TRY) begin
          // Out of tries: fold the out-of-range value back into range.
          // Since RANGE > 2^(NUM_LEN-1), the difference is always < RANGE.
          idx_d   = lfsr_in - RANGE_N;
          rem_d   = lfsr_in - RANGE_N;
          fb_d    = 1'b1;
          row_d   = '0;
          state_d = S_DIV;
        end else begin
          tries_d = tries_q + 1'b1;
        end
      end

      S_DIV: begin
        // One subtraction per cycle; the remainder ends up as the column.
        if (rem_q >= COLS_N) begin
          rem_d = rem_q - COLS_N;
          row_d = row_q + 1'b1;
        end else begin
          col_d   = rem_q[CW-1:0];
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // Hold the result until the consumer takes it; req is ignored here.
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign row      = row_q;
  assign col      = col_q;
  assign idx      = idx_q;
  assign fallback = fb_q;

endmodule

// File: tb/tb_rand_cell_picker.sv
// Bench for rand_cell_picker: a scripted or LFSR-based source feeds lfsr_in
// and steps on lfsr_en. Each request pushes its predicted result onto a
// scoreboard, and the entry is popped and compared when out_valid shows up.
module tb_rand_cell_picker;

  localparam int MAX_TRIES = 16;
  localparam int COLS      = 40;
  localparam int RANGE     = 600;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b0;
  logic       out_ready = 1'b0;
  logic [9:0] lfsr_in;
  logic       lfsr_en;
  logic       out_valid;
  logic [3:0] row;
  logic [5:0] col;
  logic [9:0] idx;
  logic       busy;
  logic       fallback;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int idx;
    int row;
    int col;
    int fb;
    int pulses;
    int lat;
  } exp_t;

  exp_t exp_q[$];

  // Stimulus source: scripted values (last one held) or a 10-bit LFSR.
  int         src_mode    = 0;
  logic [9:0] script [0:15];
  int         script_len  = 1;
  int         script_base = 0;
  int         step_cnt    = 0;
  logic [9:0] lfsr_state  = 10'h001;
  int         sidx;

  rand_cell_picker #(
    .NUM_LEN(10), .ROWS(15), .COLS(40), .MAX_TRIES(16), .RW(4), .CW(6)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .lfsr_in(lfsr_in), .lfsr_en(lfsr_en),
    .out_valid(out_valid), .out_ready(out_ready), .row(row), .col(col),
    .idx(idx), .busy(busy), .fallback(fallback)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] lfsr_next(input logic [9:0] s);
    return {s[8:0], s[9] ^ s[6]};
  endfunction

  always_comb begin
    sidx = step_cnt - script_base;
    if (sidx >= script_len) sidx = script_len - 1;
    if (sidx < 0) sidx = 0;
  end

  assign lfsr_in = (src_mode != 0) ? lfsr_state : script[sidx];

  // Upstream LFSR register: advances on every en strobe.
  always @(posedge clk) begin
    if (lfsr_en) begin
      step_cnt   <= step_cnt + 1;
      lfsr_state <= lfsr_next(lfsr_state);
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_script(input int len, input int v0, input int v1,
                             input int v2, input int v3);
    script[0]   = v0[9:0];
    script[1]   = v1[9:0];
    script[2]   = v2[9:0];
    script[3]   = v3[9:0];
    script_len  = len;
    script_base = step_cnt;
    src_mode    = 0;
  endtask

  // Reference: replay the source's future values, rejection-sample, and
  // divide with / and %.
  function automatic exp_t predict();
    exp_t       e;
    int         k;
    logic [9:0] s;
    int         v;
    e = '{default: 0};
    k = step_cnt - script_base;
    s = lfsr_state;
    for (int d = 1; d <= MAX_TRIES; d++) begin
      if (src_mode != 0) v = int'(s);
      else v = int'(script[(k >= script_len) ? script_len - 1 : k]);
      if (v < RANGE) begin
        e.idx = v; e.fb = 0; e.pulses = d;
        break;
      end
      if (d == MAX_TRIES) begin
        e.idx = v - RANGE; e.fb = 1; e.pulses = d;
        break;
      end
      k++;
      s = lfsr_next(s);
    end
    e.row = e.idx / COLS;
    e.col = e.idx % COLS;
    e.lat = e.pulses + e.row + 2;
    return e;
  endfunction

  // Issue one request, wait for the result, compare against the scoreboard,
  // optionally stall in DONE with req toggling, then complete the handshake.
  task automatic run_req(input string name, input int stall, input bit full);
    exp_t e;
    int   n;
    int   pulses;
    bit   seen;
    logic [9:0] idx_h;
    logic [3:0] row_h;
    logic [5:0] col_h;
    @(negedge clk);
    exp_q.push_back(predict());
    req = 1'b1;
    @(posedge clk);
    pulses = 0;
    seen   = 1'b0;
    n      = 1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      req = 1'b0;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      pulses += int'(lfsr_en);
      n++;
    end
    e = exp_q.pop_front();
    chk({name, "_timeout"}, seen, 1);
    if (!seen) return;
    chk({name, "_idx"}, idx, e.idx);
    chk({name, "_row"}, row, e.row);
    chk({name, "_col"}, col, e.col);
    chk({name, "_fallback"}, fallback, e.fb);
    chk({name, "_pulses"}, pulses, e.pulses);
    if (full) begin
      chk({name, "_latency"}, n, e.lat);
      chk({name, "_busy"}, busy, 1);
    end else begin
      chk({name, "_idx_range"}, (idx < 10'd600), 1);
      chk({name, "_idx_rowcol"}, idx, row * 40 + col);
      chk({name, "_pulse_max"}, (pulses <= MAX_TRIES), 1);
    end
    idx_h = idx; row_h = row; col_h = col;
    for (int s = 0; s < stall; s++) begin
      req = ~req;
      @(negedge clk);
      chk({name, "_stall_valid"}, out_valid, 1);
      chk({name, "_stall_en"}, lfsr_en, 0);
      chk({name, "_stall_idx"}, idx, idx_h);
      chk({name, "_stall_rowcol"}, {row, col}, {row_h, col_h});
    end
    req = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_drop_valid"}, out_valid, 0);
    chk({name, "_hold_idx"}, idx, idx_h);
    if (full) $display("req %s: idx=%0d row=%0d col=%0d fb=%0d pulses=%0d lat=%0d",
                       name, idx, row, col, fallback, pulses, n);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) script[i] = 10'd0;
    load_script(1, 37, 0, 0, 0);

    // Reset state
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_en", lfsr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fb", fallback, 0);
    chk("rst_outs", {row, col, idx}, 0);
    #22 rst = 1'b1;

    load_script(1, 37, 0, 0, 0);
    run_req("held37", 0, 1);
    load_script(1, 599, 0, 0, 0);
    run_req("held599", 0, 1);
    load_script(1, 1000, 0, 0, 0);
    run_req("held1000", 0, 1);
    load_script(4, 700, 700, 700, 120);
    run_req("rej3", 0, 1);
    load_script(1, 0, 0, 0, 0);
    run_req("zero", 0, 1);
    load_script(1, 455, 0, 0, 0);
    run_req("stall", 5, 1);

    // Asynchronous reset in the middle of DIV
    load_script(1, 599, 0, 0, 0);
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_en", lfsr_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_outs", {row, col, idx, fallback}, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_en", lfsr_en, 0);
    end
    $display("req async_reset: busy=%0d valid=%0d idx=%0d", busy, out_valid, idx);
    load_script(1, 123, 0, 0, 0);
    run_req("after_rst", 0, 1);

    // Real LFSR source, many requests
    src_mode = 1;
    for (int r = 0; r < 1000; r++) begin
      run_req($sformatf("lfsr%0d", r), 0, 0);
    end
    $display("req lfsr_run: 1000 requests done");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rand_cell_picker.md
Name: rand_cell_picker

Overview:
- Consumes the free-running pseudo-random word from the upstream LFSR stage and converts it into a grid cell for the game logic (e.g. food/obstacle placement).
- Draws LFSR values on request and uses rejection sampling to keep only values in [0, ROWS*COLS-1].
- Splits the accepted index into row/column with an iterative subtract divider.
- Delivers the result over a valid/ready handshake.

Parameters:
- NUM_LEN, 10, width of LFSR word consumed.
- ROWS, 15, grid rows.
- COLS, 40, grid columns; RANGE = ROWS*COLS (default 600). Legal only if 2^(NUM_LEN-1) < RANGE <= 2^NUM_LEN - 1.
- MAX_TRIES, 16, rejected draws allowed before fallback.
- RW, 4, row output width (>= clog2(ROWS)).
- CW, 6, column output width (>= clog2(COLS)).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  level request for a new cell; sampled only in IDLE.
- lfsr_in  in  NUM_LEN  current LFSR output.
- lfsr_en  out  1  advance strobe to the LFSR's en input.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- row  out  RW  picked row.
- col  out  CW  picked column.
- idx  out  NUM_LEN  linear index, row*COLS+col.
- busy  out  1  high in any state except IDLE.
- fallback  out  1  result came from the fallback path; valid with out_valid.

Behaviour:
- Reset (rst=0, async):
  - State = IDLE.
  - row, col, idx, tries, rem = 0.
  - out_valid, lfsr_en, busy, fallback = 0.
  - Reset takes effect from any state, including mid-DIV and while holding DONE; no partial result is output afterwards.
- IDLE: when req=1 at a clock edge, clear tries and fallback, then go to DRAW.
- DRAW (one cycle per draw):
  - lfsr_en=1 combinationally in every DRAW cycle. lfsr_in is sampled in the same cycle, so the LFSR steps after the value is consumed.
  - If lfsr_in < RANGE: latch idx=lfsr_in and rem=lfsr_in, set row=0, go to DIV.
  - Else if tries == MAX_TRIES-1: set idx=rem=lfsr_in-RANGE (always < RANGE given the parameter rule), set fallback=1 and row=0, go to DIV.
  - Else: tries++ and stay in DRAW.
- DIV: each cycle,
  - if rem >= COLS: rem -= COLS, row++;
  - else: col = rem, go to DONE.
  - Takes row_final+1 cycles; the maximum is ROWS cycles.
- DONE:
  - out_valid=1. row, col, idx and fallback are stable.
  - When out_valid & out_ready at an edge, go to IDLE; out_valid drops next cycle.
  - req is ignored in DONE and is not queued.
  - Outputs keep their last values in IDLE.
- Latency, first draw accepted: req edge -> 1 DRAW cycle -> row+1 DIV cycles -> out_valid. Example: row 0 gives out_valid 3 cycles after req is sampled.
- Each rejected draw adds 1 cycle.
- lfsr_en is never high outside DRAW. It pulses once per draw, so MAX_TRIES is the upper bound on pulses per request.
- lfsr_in = 0 (not produced by a maximal LFSR) is handled as a normal in-range value: row 0, col 0.
- No arithmetic overflow: rem and idx are NUM_LEN wide; tries is clog2(MAX_TRIES) bits and never wraps.

Test Plan:
- lfsr_in held at 37, req pulse -> exactly one lfsr_en pulse; out_valid 3 cycles after req sampled; row=0, col=37, idx=37, fallback=0.
- lfsr_in held at 599 -> one lfsr_en pulse; 15 DIV cycles; row=14, col=39, idx=599.
- lfsr_in held at 1000 -> 16 consecutive lfsr_en pulses, then fallback path; idx=400, row=10, col=0, fallback=1.
- lfsr_in=700 for 3 draws then 120 -> 4 lfsr_en pulses; row=3, col=0; fallback=0.
- out_ready=0 for 5 cycles in DONE with req toggling -> out_valid and outputs stable, no lfsr_en; returns to IDLE only on the handshake.
- Drive rst=0 asynchronously during DIV (lfsr_in=599) -> all outputs 0 immediately, no lfsr_en; after release with req=0, stays in IDLE.
- Drive the real upstream LFSR stage and issue 1000 requests -> every idx < 600, idx == row*40+col, lfsr_en pulses per request <= 16.
